local_predictor_param: RTL and testbench



---
 rtl/local_predictor_param.sv | 167 ++++++++++++++++
 tb/tb_local_predictor_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/local_predictor_param.sv
// Two-level local branch predictor: a PC-indexed history table selects a saturating counter.
// Define LOCAL_PRED_BYPASS_EN to forward a same-cycle update into the prediction.
module local_predictor_param #(
    parameter int PC_W         = 32,
    parameter int PC_SHIFT     = 2,
    parameter int LHT_IDX_BITS = 6,
    parameter int HIST_BITS    = 10,
    parameter int CTR_BITS     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 pred_req_valid,
    input  logic [PC_W-1:0]      pred_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_valid,
    input  logic [PC_W-1:0]      upd_pc,
    input  logic                 upd_taken
);
    localparam int LHT_ENTRIES = 1 << LHT_IDX_BITS;
    localparam int PHT_ENTRIES = 1 << HIST_BITS;
    localparam int SWEEP_BITS  = (HIST_BITS > LHT_IDX_BITS) ? HIST_BITS : LHT_IDX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

    logic [HIST_BITS-1:0] lht_mem [LHT_ENTRIES];
    logic [CTR_BITS-1:0]  pht_mem [PHT_ENTRIES];

    logic [0:0]            state_q, state_d;
    logic [SWEEP_BITS-1:0] sweep_q, sweep_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [HIST_BITS-1:0]  pred_hist_q, pred_hist_d;

    logic                    running;
    logic                    init_active;
    logic                    sweep_done;
    logic                    lht_init_en;
    logic                    pht_init_en;
    logic                    req_en;
    logic                    upd_en;
    logic [LHT_IDX_BITS-1:0] req_idx;
    logic [LHT_IDX_BITS-1:0] upd_idx;
    logic [HIST_BITS-1:0]    upd_hist;
    logic [HIST_BITS-1:0]    upd_hist_new;
    logic [CTR_BITS-1:0]     upd_ctr;
    logic [CTR_BITS-1:0]     upd_ctr_new;
    logic [HIST_BITS-1:0]    req_hist;
    logic [CTR_BITS-1:0]     req_ctr;
    logic                    unused_pc_bits;

    assign running     = (state_q == ST_RUN);
    assign init_active = (state_q == ST_INIT) && !reset;
    assign sweep_done  = &sweep_q;
    assign req_en      = running && pred_req_valid && !reset;
    assign upd_en      = running && upd_valid && !reset;

    assign req_idx        = pred_pc[PC_SHIFT +: LHT_IDX_BITS];
    assign upd_idx        = upd_pc[PC_SHIFT +: LHT_IDX_BITS];
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    // The sweep covers the larger table; the smaller one is only written while in range.
    generate
        if (SWEEP_BITS > LHT_IDX_BITS) begin : g_lht_range
            assign lht_init_en = init_active && (sweep_q[SWEEP_BITS-1:LHT_IDX_BITS] == '0);
        end else begin : g_lht_full
            assign lht_init_en = init_active;
        end
        if (SWEEP_BITS > HIST_BITS) begin : g_pht_range
            assign pht_init_en = init_active && (sweep_q[SWEEP_BITS-1:HIST_BITS] == '0);
        end else begin : g_pht_full
            assign pht_init_en = init_active;
        end
    endgenerate

    assign upd_hist     = lht_mem[upd_idx];
    assign upd_ctr      = pht_mem[upd_hist];
    assign upd_hist_new = {upd_hist[HIST_BITS-2:0], upd_taken};

    always_comb begin
        upd_ctr_new = upd_ctr;
        if (upd_taken && (upd_ctr != CTR_MAX)) begin
            upd_ctr_new = upd_ctr + CTR_BITS'(1);
        end else if (!upd_taken && (upd_ctr != '0)) begin
            upd_ctr_new = upd_ctr - CTR_BITS'(1);
        end
    end

    always_comb begin
        req_hist = lht_mem[req_idx];
`ifdef LOCAL_PRED_BYPASS_EN
        if (upd_en && (upd_idx == req_idx)) begin
            req_hist = upd_hist_new;
        end
`endif
        req_ctr = pht_mem[req_hist];
`ifdef LOCAL_PRED_BYPASS_EN
        if (upd_en && (upd_hist == req_hist)) begin
            req_ctr = upd_ctr_new;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_hist_d  = pred_hist_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + SWEEP_BITS'(1);
            if (sweep_done) begin
                state_d = ST_RUN;
            end
        end
        if (req_en) begin
            pred_valid_d = 1'b1;
            pred_taken_d = req_ctr[CTR_BITS-1];
            pred_hist_d  = req_hist;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_hist_q  <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

    // Tables carry no reset; the post-reset sweep establishes their contents.
    always_ff @(posedge clock) begin
        if (lht_init_en) begin
            lht_mem[sweep_q[LHT_IDX_BITS-1:0]] <= '0;
        end else if (upd_en) begin
            lht_mem[upd_idx] <= upd_hist_new;
        end
    end

    always_ff @(posedge clock) begin
        if (pht_init_en) begin
            pht_mem[sweep_q[HIST_BITS-1:0]] <= CTR_WEAK_NT;
        end else if (upd_en) begin
            pht_mem[upd_hist] <= upd_ctr_new;
        end
    end

    assign ready      = running;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_hist  = pred_hist_q;

endmodule

// File: tb/tb_local_predictor_param.sv
// Bench for local_predictor_param: directed vectors, corner sequences and a randomized run
// against an array-based reference model of the predictor's rules.
module tb_local_predictor_param;
    localparam int LHT_N = 64;
    localparam int PHT_N = 1024;
    localparam int C_MAX = 7;
    localparam int C_MID = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic        pred_req_valid;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [9:0]  pred_hist;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    always #5 clock = ~clock;

    local_predictor_param dut (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .pred_req_valid (pred_req_valid),
        .pred_pc        (pred_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int lht_m [LHT_N];
    int pht_m [PHT_N];
    int init_left = 0;
    bit m_valid = 0;
    bit m_taken = 0;
    int m_hist = 0;

    typedef struct {
        bit          req;
        logic [31:0] rpc;
        bit          upd;
        logic [31:0] upc;
        bit          ut;
        bit          e_valid;
        bit          e_taken;
        int          e_hist;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit req, input logic [31:0] rpc,
                              input bit upd, input logic [31:0] upc, input bit ut);
        int ri, ui, hu, hnew, cnew, hq, cq;
        if (rst) begin
            init_left = PHT_N;
            foreach (lht_m[i]) lht_m[i] = 0;
            foreach (pht_m[i]) pht_m[i] = C_MID - 1;
            m_valid = 0;
            m_taken = 0;
            m_hist  = 0;
            return;
        end
        if (init_left > 0) begin
            init_left--;
            m_valid = 0;
            return;
        end
        ri   = int'((rpc / 4) % LHT_N);
        ui   = int'((upc / 4) % LHT_N);
        hu   = lht_m[ui];
        hnew = (hu * 2 + int'(ut)) % PHT_N;
        if (ut) cnew = (pht_m[hu] < C_MAX) ? pht_m[hu] + 1 : C_MAX;
        else    cnew = (pht_m[hu] > 0) ? pht_m[hu] - 1 : 0;
        if (req) begin
            hq = lht_m[ri];
`ifdef LOCAL_PRED_BYPASS_EN
            if (upd && ui == ri) hq = hnew;
`endif
            cq = pht_m[hq];
`ifdef LOCAL_PRED_BYPASS_EN
            if (upd && hq == hu) cq = cnew;
`endif
            m_valid = 1;
            m_taken = (cq >= C_MID);
            m_hist  = hq;
        end else begin
            m_valid = 0;
        end
        if (upd) begin
            pht_m[hu] = cnew;
            lht_m[ui] = hnew;
        end
    endtask

    task automatic step(input bit rst, input bit req, input logic [31:0] rpc,
                        input bit upd, input logic [31:0] upc, input bit ut);
        reset          = rst;
        pred_req_valid = req;
        pred_pc        = rpc;
        upd_valid      = upd;
        upd_pc         = upc;
        upd_taken      = ut;
        model_step(rst, req, rpc, upd, upc, ut);
        @(posedge clock);
        #1;
        chk("model_ready", ready, (init_left == 0));
        chk("model_valid", pred_valid, m_valid);
        chk("model_taken", pred_taken, m_taken);
        chk("model_hist", pred_hist, m_hist);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        bit saw_valid = 0;
        while (ready !== 1'b1 && n < 3000) begin
            step(1'b0, 1'($urandom_range(0, 1)), 32'h40, 1'($urandom_range(0, 1)), 32'h40, 1'b1);
            if (pred_valid === 1'b1) saw_valid = 1;
            n++;
        end
        chk({tag, "_init_len"}, n, 1024);
        chk({tag, "_no_valid"}, saw_valid, 0);
        $display("[TB] %s: ready after %0d cycles", tag, n);
    endtask

    task automatic req_check(input string name, input logic [31:0] pc, input bit et, input int eh);
        step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0);
        chk({name, "_valid"}, pred_valid, 1);
        chk({name, "_taken"}, pred_taken, et);
        chk({name, "_hist"}, pred_hist, eh);
        $display("[TB] %s pc=0x%0h taken=%0d hist=0x%0h", name, pc, pred_taken, pred_hist);
    endtask

    task automatic upd_n(input logic [31:0] pc, input bit t, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b1, pc, t);
        $display("[TB] %0d updates pc=0x%0h taken=%0d", n, pc, t);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_bp_hist;
        bit exp_bp_taken;
        logic [31:0] rnd;
        logic [31:0] rpc;
        logic [31:0] upc;

        vecs[0] = '{1'b1, 32'h1234, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b1, 32'h40,   1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 32'h0,    1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 32'h40,   1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b1, 32'h80,   1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 0};
        vecs[5] = '{1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 0};

        // Reset and first sweep, with requests/updates to 0x40 during INIT
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst_ready", ready, 0);
        chk("rst_valid", pred_valid, 0);
        chk("rst_taken", pred_taken, 0);
        chk("rst_hist", pred_hist, 0);
        wait_ready("first");

        for (int i = 0; i < 6; i++) begin
            step(1'b0, vecs[i].req, vecs[i].rpc, vecs[i].upd, vecs[i].upc, vecs[i].ut);
            chk($sformatf("vec%0d_valid", i), pred_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_taken", i), pred_taken, vecs[i].e_taken);
            chk($sformatf("vec%0d_hist", i), pred_hist, vecs[i].e_hist);
            $display("[TB] vec%0d req=%0d pc=0x%0h upd=%0d upc=0x%0h t=%0d -> valid=%0d taken=%0d hist=0x%0h",
                     i, vecs[i].req, vecs[i].rpc, vecs[i].upd, vecs[i].upc, vecs[i].ut,
                     pred_valid, pred_taken, pred_hist);
        end

        // Saturation upward on PHT[0x3FF]
        upd_n(32'h40, 1'b1, 10);
        req_check("sat_hist", 32'h40, 1'b1, 10'h3FF);
        upd_n(32'h40, 1'b1, 8);
        req_check("sat_top", 32'h40, 1'b1, 10'h3FF);
        upd_n(32'h40, 1'b0, 1);
        req_check("sat_dec", 32'h40, 1'b0, 10'h3FE);
        // Saturation at zero on PHT[0] (4 -> 0, then held)
        upd_n(32'h80, 1'b0, 6);
        req_check("sat_zero", 32'h80, 1'b0, 0);
        // Another PC reaching history 0x3FF reads the counter left at 6
        upd_n(32'hC0, 1'b1, 10);
        req_check("sat_six", 32'hC0, 1'b1, 10'h3FF);

        // Reset in RUN after training
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("runrst_ready", ready, 0);
        chk("runrst_taken", pred_taken, 0);
        chk("runrst_hist", pred_hist, 0);
        wait_ready("run_rst");
        req_check("reinit_c0", 32'hC0, 1'b0, 0);
        req_check("reinit_40", 32'h40, 1'b0, 0);

        // Same-cycle request and update on the same PC
`ifdef LOCAL_PRED_BYPASS_EN
        exp_bp_hist  = 1'b1;
        exp_bp_taken = 1'b1;
`else
        exp_bp_hist  = 1'b0;
        exp_bp_taken = 1'b0;
`endif
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1);
        chk("same_pc_hist", pred_hist, exp_bp_hist);
        chk("same_pc_taken", pred_taken, 0);
        $display("[TB] same-cycle pc=0x40 -> taken=%0d hist=0x%0h", pred_taken, pred_hist);
        req_check("after_same", 32'h40, 1'b0, 1);

        // Reset mid-INIT, then a full sweep again
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 500; k++) step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1);
        chk("midinit_ready", ready, 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        wait_ready("mid_init");

        // Same-cycle update on another PC sharing PHT[0]
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
        chk("shared_pht_taken", pred_taken, exp_bp_taken);
        chk("shared_pht_hist", pred_hist, 0);
        $display("[TB] same-cycle req 0x40 / upd 0x80 -> taken=%0d hist=0x%0h", pred_taken, pred_hist);

        // Randomized traffic on a small PC set with random ignored bits
        for (int k = 0; k < 4000; k++) begin
            rnd = $urandom;
            rpc = (rnd & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            rnd = $urandom;
            upc = (rnd & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            step(($urandom_range(0, 1999) == 0), 1'($urandom_range(0, 1)), rpc,
                 ($urandom_range(0, 3) != 0), upc, ($urandom_range(0, 2) != 0));
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
